// File: rtl/booth_sm_accumulator.sv
// booth_sm_accumulator: sums a burst of sign-magnitude products in a
// saturating two's-complement accumulator and returns the result in
// sign-magnitude form together with a sticky overflow flag.
module booth_sm_accumulator #(
    parameter int BITS  = 32,
    parameter int ACC_W = 2*BITS + 8,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    input  logic                 prod_valid,
    output logic                 prod_ready,
    input  logic [2*BITS-1:0]    prod,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic [ACC_W-1:0]     acc,
    output logic                 acc_ovf,
    output logic                 busy
);

    localparam int PW = 2*BITS;

    // Largest legal magnitude; the most negative two's-complement code is
    // never kept in the accumulator, so negation always fits ACC_W-1 bits.
    localparam logic [ACC_W-1:0] MAX_POS  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MAX_NEG  = ~MAX_POS + 1'b1;
    localparam logic [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, CONV, DONE} state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   cnt;
    logic [ACC_W-1:0]   accum;
    logic [ACC_W-1:0]   mag_ext;
    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   sum_sat;
    logic [ACC_W-1:0]   accum_neg;
    logic [ACC_W-1:0]   acc_sm;
    logic               pos_ovf, neg_ovf;
    logic               fire;

    assign prod_ready = (state == ACC);
    assign acc_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign fire       = prod_valid && prod_ready;

    // Product to two's complement (negative zero negates to zero), one add,
    // overflow detection and clamping to the symmetric legal range.
    always_comb begin
        mag_ext = ACC_W'(prod[PW-2:0]);
        addend  = prod[PW-1] ? (~mag_ext + 1'b1) : mag_ext;
        sum     = accum + addend;
        pos_ovf = !accum[ACC_W-1] && !addend[ACC_W-1] && sum[ACC_W-1];
        neg_ovf = (accum[ACC_W-1] && addend[ACC_W-1] && !sum[ACC_W-1])
                  || (sum == MOST_NEG);
        if (pos_ovf)
            sum_sat = MAX_POS;
        else if (neg_ovf)
            sum_sat = MAX_NEG;
        else
            sum_sat = sum;
    end

    // Accumulator to sign-magnitude; zero naturally comes out with sign 0.
    always_comb begin
        accum_neg = ~accum + 1'b1;
        acc_sm    = accum[ACC_W-1] ? {1'b1, accum_neg[ACC_W-2:0]}
                                   : {1'b0, accum[ACC_W-2:0]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (len != '0) ? ACC : CONV;
            ACC:  if (fire && cnt == LEN_W'(1)) state_nxt = CONV;
            CONV: state_nxt = DONE;
            DONE: if (acc_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: counter, accumulator, result and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            accum   <= '0;
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cnt     <= len;
                accum   <= '0;
                acc_ovf <= 1'b0;
            end else if (fire) begin
                cnt   <= cnt - LEN_W'(1);
                accum <= sum_sat;
                if (pos_ovf || neg_ovf)
                    acc_ovf <= 1'b1;
            end
            if (state == CONV)
                acc <= acc_sm;
        end
    end

endmodule

// File: tb/tb_booth_sm_accumulator.sv
// Self-checking bench: two instances (wide and narrow), directed bursts,
// scoreboard of expected results computed by an exact-arithmetic model.
module tb_booth_sm_accumulator;

    localparam int BB = 32;
    localparam int BA = 2*BB + 8;
    localparam int SB = 4;
    localparam int SA = 9;

    typedef struct {
        bit     s;
        longint m;
    } sm_t;

    typedef struct {
        logic [127:0] acc;
        bit           ovf;
    } res_t;

    logic clk, rst_n;

    logic            b_start, b_pv, b_pr, b_av, b_ar, b_ovf, b_busy;
    logic [7:0]      b_len;
    logic [2*BB-1:0] b_prod;
    logic [BA-1:0]   b_acc;

    logic            s_start, s_pv, s_pr, s_av, s_ar, s_ovf, s_busy;
    logic [7:0]      s_len;
    logic [2*SB-1:0] s_prod;
    logic [SA-1:0]   s_acc;

    booth_sm_accumulator #(.BITS(BB), .ACC_W(BA), .LEN_W(8)) u_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .len(b_len),
        .prod_valid(b_pv), .prod_ready(b_pr), .prod(b_prod),
        .acc_valid(b_av), .acc_ready(b_ar), .acc(b_acc),
        .acc_ovf(b_ovf), .busy(b_busy)
    );

    booth_sm_accumulator #(.BITS(SB), .ACC_W(SA), .LEN_W(8)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .len(s_len),
        .prod_valid(s_pv), .prod_ready(s_pr), .prod(s_prod),
        .acc_valid(s_av), .acc_ready(s_ar), .acc(s_acc),
        .acc_ovf(s_ovf), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    res_t exp_q[$];

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic sm_t sm(bit s, longint m);
        sm_t r;
        r.s = s;
        r.m = m;
        return r;
    endfunction

    // Exact signed sum with clamping after every add, then sign-magnitude.
    function automatic res_t model(int w, sm_t p[$]);
        logic signed [127:0] a, mx, m;
        res_t r;
        r.ovf = 1'b0;
        a  = '0;
        mx = (128'sd1 <<< (w-1)) - 128'sd1;
        foreach (p[i]) begin
            m = 128'(p[i].m);
            a = p[i].s ? a - m : a + m;
            if (a > mx) begin
                a = mx;
                r.ovf = 1'b1;
            end else if (a < -mx) begin
                a = -mx;
                r.ovf = 1'b1;
            end
        end
        r.acc = (a < 0) ? ((128'd1 << (w-1)) | 128'(-a)) : 128'(a);
        return r;
    endfunction

    function automatic logic rd_av(bit sel);   return sel ? s_av   : b_av;   endfunction
    function automatic logic rd_pr(bit sel);   return sel ? s_pr   : b_pr;   endfunction
    function automatic logic rd_busy(bit sel); return sel ? s_busy : b_busy; endfunction
    function automatic logic rd_ovf(bit sel);  return sel ? s_ovf  : b_ovf;  endfunction
    function automatic logic [127:0] rd_acc(bit sel);
        return sel ? 128'(s_acc) : 128'(b_acc);
    endfunction

    task automatic set_in(bit sel, bit st, int ln, bit pv, sm_t p, bit ar);
        if (sel) begin
            s_start = st; s_len = 8'(ln); s_pv = pv; s_ar = ar;
            s_prod  = {p.s, 7'(p.m)};
        end else begin
            b_start = st; b_len = 8'(ln); b_pv = pv; b_ar = ar;
            b_prod  = {p.s, 63'(p.m)};
        end
    endtask

    // One full burst: start, products with gaps, result under backpressure.
    task automatic run_burst(bit sel, int ln, sm_t p[$], int g[$], int bp, bit pulse);
        sm_t          z;
        res_t         e;
        logic [127:0] acc0;
        int           n;
        z = sm(0, 0);
        exp_q.push_back(model(sel ? SA : BA, p));
        @(negedge clk);
        chk("idle_busy", 128'(rd_busy(sel)), 128'd0);
        set_in(sel, 1, ln, 0, z, 0);
        @(negedge clk);
        set_in(sel, 0, 0, 0, z, 0);
        chk("busy", 128'(rd_busy(sel)), 128'd1);
        foreach (p[i]) begin
            repeat (g[i]) begin
                set_in(sel, pulse, 1, 0, z, 0);
                @(negedge clk);
                chk("stall_ready", 128'(rd_pr(sel)), 128'd1);
            end
            set_in(sel, 0, 0, 1, p[i], 0);
            chk("ready", 128'(rd_pr(sel)), 128'd1);
            @(negedge clk);
            set_in(sel, 0, 0, 0, z, 0);
        end
        chk("conv_no_valid", 128'(rd_av(sel)), 128'd0);
        chk("conv_no_ready", 128'(rd_pr(sel)), 128'd0);
        @(negedge clk);
        n = 0;
        while (!rd_av(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 128'(n), 128'd0);
        acc0 = rd_acc(sel);
        repeat (bp) begin
            @(negedge clk);
            chk("bp_valid", 128'(rd_av(sel)), 128'd1);
            chk("bp_stable", rd_acc(sel), acc0);
        end
        e = exp_q.size() != 0 ? exp_q.pop_front() : '{acc: '1, ovf: 1'b0};
        chk("acc", rd_acc(sel), e.acc);
        chk("ovf", 128'(rd_ovf(sel)), 128'(e.ovf));
        set_in(sel, 0, 0, 0, z, 1);
        @(negedge clk);
        set_in(sel, 0, 0, 0, z, 0);
        chk("released", 128'(rd_av(sel)), 128'd0);
        chk("acc_kept", rd_acc(sel), e.acc);
        chk("ovf_kept", 128'(rd_ovf(sel)), 128'(e.ovf));
    endtask

    initial begin
        sm_t q[$];
        int  g[$];
        sm_t z;
        z = sm(0, 0);
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, z, 0);
        set_in(1, 0, 0, 0, z, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", 128'(b_busy), 128'd0);
        chk("rst_acc", 128'(b_acc), 128'd0);
        chk("rst_valid", 128'(s_av), 128'd0);
        rst_n = 1'b1;

        q = {sm(0, 5), sm(0, 7), sm(1, 2)};             g = {0, 0, 0};
        run_burst(0, 3, q, g, 0, 0);
        q = {sm(1, 0), sm(1, 0)};                       g = {0, 0};
        run_burst(0, 2, q, g, 0, 0);
        q = {};                                         g = {};
        run_burst(0, 0, q, g, 0, 0);
        q = {sm(1, 100), sm(0, 30), sm(1, 1), sm(0, 71)}; g = {0, 0, 3, 1};
        run_burst(0, 4, q, g, 5, 1);

        q = {sm(0, 127), sm(0, 127), sm(0, 127)};       g = {0, 0, 0};
        run_burst(1, 3, q, g, 0, 0);
        q = {sm(1, 127), sm(1, 127), sm(1, 127)};       g = {0, 1, 0};
        run_burst(1, 3, q, g, 0, 0);
        q = {sm(0, 127), sm(0, 127), sm(0, 127), sm(1, 127)}; g = {0, 0, 0, 0};
        run_burst(1, 4, q, g, 2, 0);

        // Asynchronous reset in the middle of a burst: nothing is output.
        @(negedge clk);
        set_in(0, 1, 5, 0, z, 0);
        @(negedge clk);
        set_in(0, 0, 0, 1, sm(0, 11), 0);
        @(negedge clk);
        set_in(0, 0, 0, 1, sm(0, 13), 0);
        @(negedge clk);
        set_in(0, 0, 0, 0, z, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(b_busy), 128'd0);
        chk("arst_ready", 128'(b_pr), 128'd0);
        chk("arst_valid", 128'(b_av), 128'd0);
        chk("arst_acc", 128'(b_acc), 128'd0);
        chk("arst_ovf", 128'(s_ovf), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        q = {sm(0, 9)};                                 g = {0};
        run_burst(0, 1, q, g, 0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
